// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Function : Boot loader streaming a word-count header plus big-endian words
//            into instruction memory, holding the core in reset until done.
//            Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_FIN,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    localparam logic [16:0] c_depth = 17'(DEPTH);

    state_t      r_state;
    logic [15:0] r_n;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_xfer;
    logic [15:0] w_n;

    assign w_xfer = byte_valid && byte_ready;
    assign w_n    = {r_n[15:8], byte_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HDR_HI;
            r_n        <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
            byte_ready <= 1'b1;
            im_we      <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            im_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_xfer && (r_state == S_HDR_HI || r_state == S_HDR_LO || r_state == S_DATA))
                r_xor <= r_xor ^ byte_in;
`endif
            case (r_state)
                S_HDR_HI: begin
                    if (w_xfer) begin
                        r_n[15:8] <= byte_in;
                        r_state   <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_xfer) begin
                        r_n[7:0] <= byte_in;
                        if ({1'b0, w_n} > c_depth) begin
                            r_state    <= S_ERR;
                            err        <= 1'b1;
                            byte_ready <= 1'b0;
                        end else if (w_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            load_done  <= 1'b1;
                            cpu_rst    <= 1'b0;
                            byte_ready <= 1'b0;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= {r_shift[15:0], byte_in};
                        if (r_byte_cnt == 2'd3) begin
                            im_we      <= 1'b1;
                            im_wdata   <= {r_shift, byte_in};
                            im_waddr   <= r_word_idx[ADDR_W-1:0];
                            r_word_idx <= r_word_idx + 16'd1;
                            if (r_word_idx == r_n - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state    <= S_CHK;
`else
                                r_state    <= S_FIN;
                                byte_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
                // Final write pulse is in flight; release the core next cycle.
                S_FIN: begin
                    r_state   <= S_DONE;
                    load_done <= 1'b1;
                    cpu_rst   <= 1'b0;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_in == r_xor) begin
                            r_state   <= S_DONE;
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_HDR_HI;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Function : Directed self-checking bench for imem_loader with a byte-count
//            reference model compared every cycle.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the image purely by number of accepted bytes.
    int                m_cnt   = 0;
    logic [15:0]       m_n     = '0;
    logic [31:0]       m_wd    = '0;
    logic [7:0]        m_x     = '0;
    bit                m_fin   = 1'b0;
    bit                m_done  = 1'b0;
    bit                m_err   = 1'b0;
    bit                m_we    = 1'b0;
    bit                m_ready = 1'b1;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [31:0]       m_data  = '0;
    bit                checking = 1'b0;
    int                cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_cnt = 0; m_n = '0; m_wd = '0; m_x = '0; m_fin = 0;
            m_done = 0; m_err = 0; m_we = 0; m_ready = 1; m_addr = '0; m_data = '0;
        end else begin
            m_we = 1'b0;
            if (m_fin) begin
                m_fin  = 1'b0;
                m_done = 1'b1;
            end else if (byte_valid && m_ready) begin
                m_cnt++;
                if (m_cnt == 1) begin
                    m_n[15:8] = byte_in;
                end else if (m_cnt == 2) begin
                    m_n[7:0] = byte_in;
                    if (int'(m_n) > DEPTH) m_err = 1'b1;
                    else if (m_n == 16'd0 && !CK) m_done = 1'b1;
                end else if (m_cnt <= 2 + 4 * int'(m_n)) begin
                    m_wd = {m_wd[23:0], byte_in};
                    if ((m_cnt - 2) % 4 == 0) begin
                        m_we   = 1'b1;
                        m_addr = ADDR_W'((m_cnt - 2) / 4 - 1);
                        m_data = m_wd;
                        if (m_cnt == 2 + 4 * int'(m_n) && !CK) m_fin = 1'b1;
                    end
                end else begin
                    if (byte_in == m_x) m_done = 1'b1;
                    else m_err = 1'b1;
                end
                m_x = m_x ^ byte_in;
            end
            m_ready = !(m_done || m_err || m_fin);
        end
    end

    // Per-cycle compare plus write log / timing capture.
    logic [ADDR_W-1:0] log_a[$];
    logic [31:0]       log_d[$];
    int                last_we_cyc = -100;
    int                done_cyc = -1;
    logic              prev_done = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            check("we", 32'(im_we), 32'(m_we));
            check("waddr", 32'(im_waddr), 32'(m_addr));
            check("wdata", im_wdata, m_data);
            check("load_done", 32'(load_done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("cpu_rst", 32'(cpu_rst), 32'(!m_done));
            if (!m_fin) check("byte_ready", 32'(byte_ready), 32'(m_ready));
        end
        if (im_we === 1'b1) begin
            log_a.push_back(im_waddr);
            log_d.push_back(im_wdata);
            last_we_cyc = cyc;
        end
        if (load_done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done = load_done;
    end

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready) begin
                @(posedge clk); #1;
                byte_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++; fails++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        log_a.delete(); log_d.delete();
        done_cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_waddr", 32'(im_waddr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        log_a.delete(); log_d.delete();

        // 1: two words back-to-back
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'h8D); send(8'h09); send(8'h00); send(8'h04);
        if (CK) send(8'hAF);
        idle(3);
        check("t1_nwrites", 32'(log_a.size()), 32'd2);
        if (log_a.size() == 2) begin
            check("t1_a0", 32'(log_a[0]), 32'd0);
            check("t1_d0", log_d[0], 32'h20080005);
            check("t1_a1", 32'(log_a[1]), 32'd1);
            check("t1_d1", log_d[1], 32'h8D090004);
        end
        check("t1_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd0);

        // 2: oversize header, byte_valid held high in ERR
        do_reset();
        send(8'h01); send(8'h01);
        check("t2_err", 32'(err), 32'd1);
        check("t2_ready", 32'(byte_ready), 32'd0);
        byte_in = 8'hFF; byte_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        byte_valid = 1'b0;
        check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t2_nwrites", 32'(log_a.size()), 32'd0);

        // 3: N=1 with stalls between payload bytes
        do_reset();
        send(8'h00); send(8'h01);
        send(8'h12); idle(1); send(8'h34); idle(1); send(8'h56); idle(1); send(8'h78);
        if (CK) send(8'h09);
        idle(3);
        check("t3_nwrites", 32'(log_a.size()), 32'd1);
        if (log_a.size() == 1) begin
            check("t3_a0", 32'(log_a[0]), 32'd0);
            check("t3_d0", log_d[0], 32'h12345678);
        end
        check("t3_done", 32'(load_done), 32'd1);

        // 4: reset mid-word, then fresh image
        do_reset();
        send(8'h00); send(8'h01); send(8'h55); send(8'h66);
        do_reset();
        send(8'h00); send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        if (CK) send(8'h01);
        idle(3);
        check("t4_nwrites", 32'(log_a.size()), 32'd1);
        if (log_a.size() == 1) begin
            check("t4_a0", 32'(log_a[0]), 32'd0);
            check("t4_d0", log_d[0], 32'hAABBCCDD);
        end
        check("t4_done", 32'(load_done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 5: checksum good / bad
        do_reset();
        send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h45);
        check("t5_done", 32'(load_done), 32'd1);
        check("t5_noerr", 32'(err), 32'd0);
        do_reset();
        send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h46);
        check("t5_err", 32'(err), 32'd1);
        check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        idle(2);
        // 6 (checksum build): empty image still needs its checksum byte
        do_reset();
        send(8'h00); send(8'h00);
        check("t6_not_done", 32'(load_done), 32'd0);
        send(8'h00);
        check("t6_done", 32'(load_done), 32'd1);
        idle(3);
        check("t6_nwrites", 32'(log_a.size()), 32'd0);
`else
        // 6: empty image completes right after the header
        do_reset();
        send(8'h00); send(8'h00);
        check("t6_done", 32'(load_done), 32'd1);
        check("t6_cpu_rst", 32'(cpu_rst), 32'd0);
        idle(3);
        check("t6_nwrites", 32'(log_a.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
